// File: rtl/d_flip_flop.sv
// d_flip_flop: parameterized D register / fixed-latency delay line.
// STAGES cascaded registers, asynchronous active-high reset, synchronous
// clear (overrides enable) and clock enable. Q is the last stage, Qn = ~Q.
module d_flip_flop #(
  parameter int              WIDTH       = 1,
  parameter int              STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  // Reject degenerate configurations at elaboration time.
  if (WIDTH < 1) begin : g_width_check
    $error("d_flip_flop: WIDTH must be >= 1 (got %0d)", WIDTH);
  end
  if (STAGES < 1) begin : g_stages_check
    $error("d_flip_flop: STAGES must be >= 1 (got %0d)", STAGES);
  end

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  // Next-state of the chain: clear beats enable; enable shifts D in at stage 0.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (clr) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_d[i] = RESET_VALUE;
      end
    end else if (en) begin
      stage_d[0] = D;
      for (int i = 1; i < STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // Stage registers; reset forces every stage so nothing stale survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign Q  = stage_q[STAGES-1];
  assign Qn = ~Q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Testbench for d_flip_flop: a default single-bit instance and an
// 8-bit / 3-stage / reset-value 8'hA5 instance driven by shared controls.
module tb_d_flip_flop;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic       d1;
  logic       q1, qn1;
  logic [7:0] d8;
  logic [7:0] q8, qn8;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: history of accepted words since last reset/clear.
  logic       h1 [$];
  logic [7:0] h8 [$];

  d_flip_flop dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .D(d1), .Q(q1), .Qn(qn1)
  );

  d_flip_flop #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .D(d8), .Q(q8), .Qn(qn8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       en;
    logic       clr;
    logic       d1;
    logic [7:0] d8;
    logic       q1;
    logic [7:0] q8;
  } vec_t;

  vec_t tbl [17];

  function automatic logic exp1();
    int n = h1.size();
    return (n >= 1) ? h1[n-1] : 1'b0;
  endfunction

  function automatic logic [7:0] exp8();
    int n = h8.size();
    return (n >= 3) ? h8[n-3] : 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e1, input logic [7:0] e8);
    chk({tag, ".Q1"},  {7'd0, q1},  {7'd0, e1});
    chk({tag, ".Qn1"}, {7'd0, qn1}, {7'd0, ~e1});
    chk({tag, ".Q8"},  q8,  e8);
    chk({tag, ".Qn8"}, qn8, ~e8);
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, exp1(), exp8());
  endtask

  // One rising edge; model follows rst > clr > en; sample 1 ns later.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      if (clr) begin
        h1.delete();
        h8.delete();
      end else if (en) begin
        h1.push_back(d1);
        h8.push_back(d8);
      end
    end
    #1;
  endtask

  // Raise rst between edges and check outputs change with no clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    h1.delete();
    h8.delete();
    #1;
    chk_all(tag, 1'b0, 8'hA5);
  endtask

  initial begin
    // vector: en clr d1 d8 -> q1 q8
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 8'hA5};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 8'hA5};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 8'h01};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 8'h02};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 8'h02};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h06, 1'b1, 8'h02};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 8'h03};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h08, 1'b0, 8'h04};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h09, 1'b1, 8'h07};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h07};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h07};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h07};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hA5};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'hA5};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 8'hA5};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 8'hA5};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 8'h12, 1'b0, 8'h10};

    rst = 1'b0; en = 1'b0; clr = 1'b0; d1 = 1'b0; d8 = 8'h00;
    #1;
    rst = 1'b1;
    #1;
    chk_all("reset_async", 1'b0, 8'hA5);
    d1 = 1'b1; d8 = 8'h77; en = 1'b1;
    step();
    chk_all("reset_hold", 1'b0, 8'hA5);
    rst = 1'b0;

    // Directed table: basic toggling, stall, clear, clear-over-enable.
    for (int i = 0; i < 17; i++) begin
      en  = tbl[i].en;
      clr = tbl[i].clr;
      d1  = tbl[i].d1;
      d8  = tbl[i].d8;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].q1, tbl[i].q8);
    end

    // Async reset mid-stream: Q1 = 1, Q8 = 8'h11 before the reset hits.
    en = 1'b1; clr = 1'b0; d1 = 1'b1; d8 = 8'h13;
    step();
    chk_all("pre_rst", 1'b1, 8'h11);
    async_reset("rst_mid");
    step();
    chk_all("rst_held1", 1'b0, 8'hA5);
    step();
    chk_all("rst_held2", 1'b0, 8'hA5);
    rst = 1'b0;
    d8 = 8'h21; d1 = 1'b0;
    step();
    chk_all("rel0", 1'b0, 8'hA5);
    d8 = 8'h22; d1 = 1'b1;
    step();
    chk_all("rel1", 1'b1, 8'hA5);
    d8 = 8'h23; d1 = 1'b0;
    step();
    chk_all("rel2", 1'b0, 8'h21);
    d8 = 8'h24;
    step();
    chk_all("rel3", 1'b0, 8'h22);

    // Randomized traffic against the history model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset("rnd_rst");
        step();
        chk_model("rnd_rst_edge");
        rst = 1'b0;
      end
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      d1  = 1'($urandom);
      d8  = 8'($urandom);
      step();
      chk_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
